// File: rtl/dbus_pair_server.sv
// Serialises the memory stage's two dbus slot requests (slot 1 first) onto one downstream bus and buffers the per-slot responses.
// Latency: a lone op answered in its first issue cycle completes two cycles after the request is seen. Downstream stalls hold mreq; all_done stalls the pipeline.
module dbus_pair_server #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int REQ_W  = 1 + ADDR_W + 3 + STRB_W + DATA_W,
  localparam int RESP_W = 2 + DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [2*REQ_W-1:0]   i_dreq,
  input  logic                 i_advance,
  input  logic                 i_flush,
  output logic [2*RESP_W-1:0]  o_dresp,
  output logic                 o_all_done,
  output logic [REQ_W-1:0]     o_mreq,
  input  logic [RESP_W-1:0]    i_mresp
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [REQ_W-1:0]  r_lat [2];
  logic [DATA_W-1:0] r_buf [2];
  logic              r_sel, w_sel_nxt;
  logic [1:0]        r_pend, w_pend_nxt;
  logic [1:0]        r_done, w_done_nxt;
  logic              r_kill, w_kill_nxt;
  logic              w_latch, w_complete, w_buf_we;
  logic [REQ_W-1:0]  w_cur, w_mreq;
  logic              w_v1, w_v0, w_addr_ok, w_data_ok;

  assign w_v1      = i_dreq[2*REQ_W-1];
  assign w_v0      = i_dreq[REQ_W-1];
  assign w_addr_ok = i_mresp[RESP_W-1];
  assign w_data_ok = i_mresp[RESP_W-2];
  assign w_cur     = r_lat[r_sel];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_pend_nxt  = r_pend;
    w_done_nxt  = r_done;
    w_kill_nxt  = r_kill;
    w_latch     = 1'b0;
    w_complete  = 1'b0;
    w_buf_we    = 1'b0;
    w_mreq      = '0;
    case (r_state)
      S_IDLE: begin
        if (!i_flush && (w_v1 || w_v0)) begin
          w_latch     = 1'b1;
          w_pend_nxt  = {w_v1, w_v0};
          w_sel_nxt   = w_v1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An accepted-in-progress request is never withdrawn; a flush only marks the pair dead.
        w_mreq          = w_cur;
        w_mreq[REQ_W-1] = 1'b1;
        if (i_flush) w_kill_nxt = 1'b1;
        if (w_addr_ok) begin
          if (w_data_ok) w_complete  = 1'b1;
          else           w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_flush)   w_kill_nxt = 1'b1;
        if (w_data_ok) w_complete = 1'b1;
      end
      S_HOLD: begin
        if (i_advance || i_flush) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 2'b00;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_complete) begin
      w_buf_we              = (w_cur[DATA_W +: STRB_W] == '0);
      w_pend_nxt[r_sel]     = 1'b0;
      w_done_nxt[r_sel]     = 1'b1;
      if (r_kill || i_flush) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 2'b00;
        w_pend_nxt  = 2'b00;
        w_kill_nxt  = 1'b0;
      end else if (r_pend[~r_sel]) begin
        w_sel_nxt   = ~r_sel;
        w_state_nxt = S_ISSUE;
      end else begin
        w_state_nxt = S_HOLD;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_lat[0] <= '0;
      r_lat[1] <= '0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_sel    <= 1'b0;
      r_pend   <= 2'b00;
      r_done   <= 2'b00;
      r_kill   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_lat[1] <= i_dreq[2*REQ_W-1:REQ_W];
        r_lat[0] <= i_dreq[REQ_W-1:0];
      end
      if (w_buf_we) r_buf[r_sel] <= i_mresp[DATA_W-1:0];
      r_sel  <= w_sel_nxt;
      r_pend <= w_pend_nxt;
      r_done <= w_done_nxt;
      r_kill <= w_kill_nxt;
    end
  end

  assign o_mreq     = w_mreq;
  assign o_dresp    = {r_done[1], r_done[1], r_buf[1], r_done[0], r_done[0], r_buf[0]};
  assign o_all_done = (r_state == S_HOLD) || ((r_state == S_IDLE) && !w_v1 && !w_v0);

endmodule

// File: tb/tb_dbus_pair_server.sv
// Directed and randomised pairs against a slot-order/buffer reference model with a randomised downstream responder.
module tb_dbus_pair_server;
  logic         i_clk = 1'b0;
  logic         i_resetn;
  logic [143:0] i_dreq;
  logic         i_advance, i_flush;
  logic [67:0]  o_dresp;
  logic         o_all_done;
  logic [71:0]  o_mreq;
  logic [33:0]  i_mresp;

  dbus_pair_server dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_dreq(i_dreq), .i_advance(i_advance),
    .i_flush(i_flush), .o_dresp(o_dresp), .o_all_done(o_all_done),
    .o_mreq(o_mreq), .i_mresp(i_mresp)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_buf [2];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk_req(input bit load);
    logic [3:0] strb;
    strb = load ? 4'd0 : 4'($urandom_range(1, 15));
    return {1'b1, 32'($urandom), 3'($urandom_range(0, 2)), strb, 32'($urandom)};
  endfunction

  task automatic cyc_begin();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_slots(input string tag, input bit [1:0] done_m);
    chk({tag, "_ok"}, {o_dresp[67], o_dresp[66], o_dresp[33], o_dresp[32]},
        {done_m[1], done_m[1], done_m[0], done_m[0]});
    chk({tag, "_data"}, {o_dresp[65:34], o_dresp[31:0]}, {m_buf[1], m_buf[0]});
  endtask

  // ad/dd < 0 picks random per-op delays; flush_op is the issue-order index flushed in its WAIT phase.
  task automatic run_pair(input bit v1, input bit v0, input bit ld1, input bit ld0,
                          input int ad_in, input int dd_in, input int flush_op);
    logic [71:0] req [2];
    int ad [2];
    int dd [2];
    int order [$];
    bit [1:0] done_m;
    int op, phase, cnt, cyc, s;
    bit killed, cmp;
    logic [31:0] rd;
    req[1] = v1 ? mk_req(ld1) : 72'd0;
    req[0] = v0 ? mk_req(ld0) : 72'd0;
    if (v1) order.push_back(1);
    if (v0) order.push_back(0);
    for (int i = 0; i < 2; i++) begin
      ad[i] = (ad_in < 0) ? $urandom_range(0, 3) : ad_in;
      dd[i] = (dd_in < 0) ? $urandom_range(0, 3) : dd_in;
    end
    if (flush_op >= 0 && flush_op < order.size() && dd[order[flush_op]] < 2)
      dd[order[flush_op]] = 2;

    cyc_begin();
    i_dreq = {req[1], req[0]}; i_mresp = '0; i_flush = 0; i_advance = 0;
    #1;
    chk("idle_req_alldone", o_all_done, 0);
    chk("idle_mreq_vld", o_mreq[71], 0);

    op = 0; phase = 0; cnt = ad[order[0]]; killed = 0; done_m = 2'b00; cyc = 0;
    while (op < order.size() && !killed && cyc <= 200) begin
      cyc_begin();
      i_dreq = '0; i_mresp = '0; i_flush = 0; i_advance = 1'($urandom_range(0, 1));
      s = order[op]; cmp = 0; rd = $urandom;
      if (phase == 0) begin
        chk("mreq_issue", o_mreq, req[s]);
        if (cnt > 0) cnt--;
        else begin
          i_mresp[33] = 1'b1;
          if (dd[s] == 0) cmp = 1;
          else begin phase = 1; cnt = dd[s]; end
        end
      end else begin
        chk("mreq_wait_vld", o_mreq[71], 0);
        if (flush_op == op && cnt == dd[s]) i_flush = 1'b1;
        if (cnt > 1) cnt--;
        else cmp = 1;
      end
      if (cmp) begin i_mresp[32] = 1'b1; i_mresp[31:0] = rd; end
      #1;
      chk("busy_alldone", o_all_done, 0);
      check_slots("busy_dresp", done_m);
      if (cmp) begin
        if (req[s][35:32] == 4'd0) m_buf[s] = rd;
        done_m[s] = 1'b1;
        if (flush_op == op) begin killed = 1; done_m = 2'b00; end
        op++; phase = 0;
        if (op < order.size()) cnt = ad[order[op]];
      end
      cyc++;
    end
    chk("pair_timeout", cyc > 200, 0);

    if (killed) begin
      for (int k = 0; k < 3; k++) begin
        cyc_begin();
        i_mresp = '0; i_advance = 0; i_flush = 0;
        #1;
        chk("kill_mreq_vld", o_mreq[71], 0);
        chk("kill_alldone_empty", o_all_done, 1);
        check_slots("kill_dresp", 2'b00);
      end
    end else begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        cyc_begin();
        i_mresp = '0; i_advance = 0; i_flush = 0;
        #1;
        chk("hold_alldone", o_all_done, 1);
        chk("hold_mreq_vld", o_mreq[71], 0);
        check_slots("hold_dresp", done_m);
      end
      cyc_begin();
      i_advance = 1;
      #1;
      chk("hold_adv_alldone", o_all_done, 1);
      cyc_begin();
      i_advance = 0;
      #1;
      check_slots("post_adv_dresp", 2'b00);
      chk("post_adv_alldone", o_all_done, 1);
    end
  endtask

  initial begin
    logic [71:0] rq;
    m_buf[0] = '0; m_buf[1] = '0;
    i_resetn = 0; i_dreq = '0; i_advance = 0; i_flush = 0; i_mresp = '0;
    #12;
    chk("rst_mreq", o_mreq, 0);
    chk("rst_dresp", o_dresp, 0);
    chk("rst_alldone", o_all_done, 1);
    @(negedge i_clk);
    i_resetn = 1;

    // Single load in slot 1, answered immediately.
    run_pair(1, 0, 1, 0, 0, 0, -1);
    // Store in slot 1 then load in slot 0, data two cycles after address.
    run_pair(1, 1, 0, 1, 0, 2, -1);

    // Empty pair: done combinationally, nothing issued.
    for (int k = 0; k < 4; k++) begin
      cyc_begin();
      i_dreq = '0; i_advance = 1'($urandom_range(0, 1));
      #1;
      chk("empty_alldone", o_all_done, 1);
      chk("empty_mreq_vld", o_mreq[71], 0);
    end
    i_advance = 0;

    // Address grant withheld five cycles.
    run_pair(0, 1, 1, 1, 5, 1, -1);
    // Flush while slot 1 waits for data: slot 0 must never be issued.
    run_pair(1, 1, 1, 1, 0, 3, 0);

    for (int n = 0; n < 30; n++) begin
      bit v1, v0;
      v1 = 1'($urandom_range(0, 1));
      v0 = v1 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_pair(v1, v0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1);
    end

    // Reset while waiting for data.
    rq = mk_req(1);
    cyc_begin();
    i_dreq = {72'd0, rq}; i_mresp = '0;
    cyc_begin();
    chk("rst_case_issue", o_mreq, rq);
    i_mresp[33] = 1'b1;
    cyc_begin();
    i_mresp = '0;
    chk("rst_case_wait_vld", o_mreq[71], 0);
    #2;
    i_resetn = 0;
    #1;
    chk("async_rst_mreq", o_mreq, 0);
    chk("async_rst_dresp", o_dresp, 0);
    chk("async_rst_alldone", o_all_done, 0);
    m_buf[0] = '0; m_buf[1] = '0;
    @(negedge i_clk);
    i_dreq = '0;
    i_resetn = 1;
    run_pair(0, 1, 0, 1, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
